// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_pkg
//  Purpose  : Shared encodings for the 21-bit single-cycle core instruction
//             word: mnemonic enum, opcode/func constants, field positions
//             and small packing helpers. The ALU control decoder on the
//             consumer side imports the same constants.
//  Revision : 1.0  initial release
// ============================================================================
package instr_pkg;

    localparam int WORD_W = 21;

    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_ORI  = 4'd3,
        MN_SLTI = 4'd4,
        MN_ADDI = 4'd5,
        MN_LW   = 4'd6,
        MN_SW   = 4'd7,
        MN_BEQ  = 4'd8,
        MN_J    = 4'd9
    } mnem_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } enc_state_e;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ORI   = 5'b11000;
    localparam logic [4:0] OP_SLTI  = 5'b10010;
    localparam logic [4:0] OP_ADDI  = 5'b00100;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b01100;
    localparam logic [4:0] OP_BEQ   = 5'b01111;
    localparam logic [4:0] OP_J     = 5'b00111;

    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b011;

    localparam int OP_MSB  = 20;
    localparam int OP_LSB  = 16;
    localparam int RS_MSB  = 15;
    localparam int RS_LSB  = 13;
    localparam int RT_MSB  = 12;
    localparam int RT_LSB  = 10;
    localparam int RD_MSB  = 9;
    localparam int RD_LSB  = 7;
    localparam int FN_MSB  = 2;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 9;
    localparam int IMM_LSB = 0;
    localparam int JA_MSB  = 15;
    localparam int JA_LSB  = 0;

    // R format: bits [6:3] are left zero.
    function automatic logic [WORD_W-1:0] pack_r(input logic [4:0] op,
                                                 input logic [2:0] rs,
                                                 input logic [2:0] rt,
                                                 input logic [2:0] rd,
                                                 input logic [2:0] fn);
        logic [WORD_W-1:0] w;
        w                 = '0;
        w[OP_MSB:OP_LSB]  = op;
        w[RS_MSB:RS_LSB]  = rs;
        w[RT_MSB:RT_LSB]  = rt;
        w[RD_MSB:RD_LSB]  = rd;
        w[FN_MSB:FN_LSB]  = fn;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] pack_i(input logic [4:0] op,
                                                 input logic [2:0] rs,
                                                 input logic [2:0] rt,
                                                 input logic [9:0] imm);
        logic [WORD_W-1:0] w;
        w                  = '0;
        w[OP_MSB:OP_LSB]   = op;
        w[RS_MSB:RS_LSB]   = rs;
        w[RT_MSB:RT_LSB]   = rt;
        w[IMM_MSB:IMM_LSB] = imm;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] pack_j(input logic [4:0]  op,
                                                 input logic [15:0] jaddr);
        logic [WORD_W-1:0] w;
        w                = '0;
        w[OP_MSB:OP_LSB] = op;
        w[JA_MSB:JA_LSB] = jaddr;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_word_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_word_encoder_if
//  Purpose  : Bundle between the boot/test loader, the instruction word
//             encoder and instruction memory.
//  Ports    : load_start/start_addr   load restart control
//             in_valid/in_ready       operand bundle handshake
//             mnem/rs/rt/rd/imm/jaddr operand bundle
//             imem_we/addr/wdata/ack  memory write request + acknowledge
//             full/err/words_written  load status
//  Modports : master - loader/memory side, slave - encoder
//  Revision : 1.0  initial release
// ============================================================================
interface instr_word_encoder_if #(
    parameter int ADDR_W = 8
);
    logic                          load_start;
    logic [ADDR_W-1:0]             start_addr;
    logic                          in_valid;
    logic                          in_ready;
    logic [3:0]                    mnem;
    logic [2:0]                    rs;
    logic [2:0]                    rt;
    logic [2:0]                    rd;
    logic [9:0]                    imm;
    logic [15:0]                   jaddr;
    logic                          imem_we;
    logic [ADDR_W-1:0]             imem_addr;
    logic [instr_pkg::WORD_W-1:0]  imem_wdata;
    logic                          imem_ack;
    logic                          full;
    logic                          err;
    logic [ADDR_W:0]               words_written;

    modport master (
        output load_start, start_addr, in_valid, mnem, rs, rt, rd, imm, jaddr,
        output imem_ack,
        input  in_ready, imem_we, imem_addr, imem_wdata, full, err, words_written
    );

    modport slave (
        input  load_start, start_addr, in_valid, mnem, rs, rt, rd, imm, jaddr,
        input  imem_ack,
        output in_ready, imem_we, imem_addr, imem_wdata, full, err, words_written
    );
endinterface
`default_nettype wire

// File: rtl/instr_field_pack.sv
`default_nettype none
// ============================================================================
//  Module   : instr_field_pack
//  Purpose  : Combinational formatter: mnemonic + operand fields -> legal flag
//             and 21-bit instruction word. Holds all format knowledge so the
//             handshake FSM only sees {legal, word}.
//  Ports    : i_mnem, i_rs, i_rt, i_rd, i_imm, i_jaddr  operand bundle
//             o_legal  mnemonic is 0..9
//             o_word   encoded word (zero for illegal mnemonics)
//  Revision : 1.0  initial release
// ============================================================================
module instr_field_pack
    import instr_pkg::*;
(
    input  wire logic [3:0]        i_mnem,
    input  wire logic [2:0]        i_rs,
    input  wire logic [2:0]        i_rt,
    input  wire logic [2:0]        i_rd,
    input  wire logic [9:0]        i_imm,
    input  wire logic [15:0]       i_jaddr,
    output logic                   o_legal,
    output logic [WORD_W-1:0]      o_word
);

    always_comb begin
        o_legal = 1'b1;
        o_word  = '0;
        case (i_mnem)
            MN_ADD:  o_word = pack_r(OP_RTYPE, i_rs, i_rt, i_rd, FN_ADD);
            MN_SUB:  o_word = pack_r(OP_RTYPE, i_rs, i_rt, i_rd, FN_SUB);
            MN_AND:  o_word = pack_r(OP_RTYPE, i_rs, i_rt, i_rd, FN_AND);
            MN_ORI:  o_word = pack_i(OP_ORI,  i_rs, i_rt, i_imm);
            MN_SLTI: o_word = pack_i(OP_SLTI, i_rs, i_rt, i_imm);
            MN_ADDI: o_word = pack_i(OP_ADDI, i_rs, i_rt, i_imm);
            MN_LW:   o_word = pack_i(OP_LW,   i_rs, i_rt, i_imm);
            MN_SW:   o_word = pack_i(OP_SW,   i_rs, i_rt, i_imm);
            MN_BEQ:  o_word = pack_i(OP_BEQ,  i_rs, i_rt, i_imm);
            MN_J:    o_word = pack_j(OP_J, i_jaddr);
            default: o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_word_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_word_encoder
//  Purpose  : Sequential instruction assembler. Accepts operand bundles over
//             valid/ready, encodes them and writes each word to instruction
//             memory at an auto-incrementing address.
//  Ports    : clk   system clock, rising edge
//             rst   asynchronous active-high reset
//             bus   instr_word_encoder_if.slave (handshake, memory, status)
//  Revision : 1.0  initial release
// ============================================================================
module instr_word_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    instr_word_encoder_if.slave     bus
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = {ADDR_W{1'b1}};

    enc_state_e             r_state;
    logic                   r_in_ready;
    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [WORD_W-1:0]      r_wdata;
    logic                   r_full;
    logic                   r_err;
    logic [ADDR_W:0]        r_count;

    logic                   w_legal;
    logic [WORD_W-1:0]      w_word;
    logic                   w_accept;

    instr_field_pack u_pack (
        .i_mnem  (bus.mnem),
        .i_rs    (bus.rs),
        .i_rt    (bus.rt),
        .i_rd    (bus.rd),
        .i_imm   (bus.imm),
        .i_jaddr (bus.jaddr),
        .o_legal (w_legal),
        .o_word  (w_word)
    );

    // r_in_ready is only ever high in IDLE with full clear.
    assign w_accept = bus.in_valid & r_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else if (bus.load_start) begin
            // Restart overrides everything, including an unacknowledged write.
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= bus.start_addr;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_wdata    <= w_word;
                            r_we       <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_state    <= ST_WRITE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.imem_ack) begin
                        r_count <= r_count + 1'b1;
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                        // The last slot stays addressed; full blocks further accepts.
                        if (r_addr == C_LAST_ADDR) begin
                            r_full     <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_addr     <= r_addr + 1'b1;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= ~r_full;
                    r_we       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.imem_we       = r_we;
    assign bus.imem_addr     = r_addr;
    assign bus.imem_wdata    = r_wdata;
    assign bus.full          = r_full;
    assign bus.err           = r_err;
    assign bus.words_written = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_word_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_word_encoder
//  Purpose  : Self-checking bench for instr_word_encoder. Expected memory
//             writes are queued when a bundle is issued; a monitor pops and
//             compares them whenever the encoder's write is acknowledged.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_word_encoder;

    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst;

    instr_word_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_word_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [28:0]        exp_q[$];
    logic [ADDR_W-1:0]  exp_addr;
    logic [ADDR_W:0]    exp_count;
    logic               exp_full;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: an acknowledged write must match the oldest expectation.
    always @(negedge clk) begin : mon
        logic [28:0] e;
        if (rst === 1'b0 && bus.imem_we === 1'b1 && bus.imem_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h, required none",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.imem_addr), 32'(e[28:21]));
                check("wr_data", 32'(bus.imem_wdata), 32'(e[20:0]));
            end
        end
    end

    task automatic check_reset_values();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_wdata", 32'(bus.imem_wdata), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_count", 32'(bus.words_written), 32'd0);
    endtask

    task automatic load(input logic [ADDR_W-1:0] a);
        bus.start_addr = a;
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        exp_addr  = a;
        exp_count = '0;
        exp_full  = 1'b0;
        check("load_we", 32'(bus.imem_we), 32'd0);
        check("load_addr", 32'(bus.imem_addr), 32'(a));
        check("load_full", 32'(bus.full), 32'd0);
        check("load_err", 32'(bus.err), 32'd0);
        check("load_count", 32'(bus.words_written), 32'd0);
        check("load_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Presents a bundle and returns one cycle (+1ns) after the accepting edge.
    task automatic send(input logic [3:0] m, input logic [2:0] s, input logic [2:0] t,
                        input logic [2:0] d, input logic [9:0] im, input logic [15:0] ja);
        logic acc;
        int   n;
        n = 0;
        bus.mnem = m; bus.rs = s; bus.rt = t; bus.rd = d; bus.imm = im; bus.jaddr = ja;
        bus.in_valid = 1'b1;
        forever begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc === 1'b1) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", n);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] m, input logic [2:0] s, input logic [2:0] t,
                              input logic [2:0] d, input logic [9:0] im, input logic [15:0] ja,
                              input logic [20:0] word, input int wait_cyc);
        exp_q.push_back({exp_addr, word});
        send(m, s, t, d, im, ja);
        check("we_after_accept", 32'(bus.imem_we), 32'd1);
        check("ready_in_write", 32'(bus.in_ready), 32'd0);
        check("wdata", 32'(bus.imem_wdata), 32'(word));
        for (int i = 0; i < wait_cyc; i++) begin
            @(posedge clk); #1;
            check("we_held", 32'(bus.imem_we), 32'd1);
            check("data_held", 32'(bus.imem_wdata), 32'(word));
            check("addr_held", 32'(bus.imem_addr), 32'(exp_addr));
            check("count_held", 32'(bus.words_written), 32'(exp_count));
        end
        bus.imem_ack = 1'b1;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        exp_count = exp_count + 1'b1;
        if (exp_addr == {ADDR_W{1'b1}}) exp_full = 1'b1;
        else                            exp_addr = exp_addr + 1'b1;
        check("count", 32'(bus.words_written), 32'(exp_count));
        check("we_drop", 32'(bus.imem_we), 32'd0);
        check("full", 32'(bus.full), 32'(exp_full));
        check("ready_after_ack", 32'(bus.in_ready), 32'(!exp_full));
        check("next_addr", 32'(bus.imem_addr), 32'(exp_addr));
    endtask

    // Remaining I/R formats: mnem, rs, rt, rd, imm, expected word.
    logic [3:0]  t_mn [5] = '{4'd2, 4'd4, 4'd6, 4'd7, 4'd8};
    logic [2:0]  t_rs [5] = '{3'd4, 3'd3, 3'd6, 3'd5, 3'd1};
    logic [2:0]  t_rt [5] = '{3'd5, 3'd1, 3'd2, 3'd4, 3'd1};
    logic [2:0]  t_rd [5] = '{3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [9:0]  t_im [5] = '{10'h000, 10'h200, 10'h004, 10'h010, 10'h3FE};
    logic [20:0] t_ex [5] = '{21'h009703, 21'h126600, 21'h08C804, 21'h0CB010, 21'h0F27FE};

    initial begin
        rst = 1'b1;
        bus.load_start = 1'b0; bus.start_addr = '0; bus.in_valid = 1'b0;
        bus.mnem = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.imm = '0; bus.jaddr = '0;
        bus.imem_ack = 1'b0;
        exp_addr = '0; exp_count = '0; exp_full = 1'b0;

        @(posedge clk); #1;
        check_reset_values();
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic writes from 0x10, with and without ack back-pressure.
        load(8'h10);
        write_word(4'd0, 3'd1, 3'd2, 3'd3, 10'h000, 16'h0000, 21'h002982, 0);
        write_word(4'd3, 3'd0, 3'd5, 3'd0, 10'h3FF, 16'h0000, 21'h1817FF, 3);
        write_word(4'd9, 3'd0, 3'd0, 3'd0, 10'h000, 16'hBEEF, 21'h07BEEF, 3);

        // Illegal mnemonic: consumed, flagged, nothing written.
        send(4'd12, 3'd0, 3'd0, 3'd0, 10'h000, 16'h0000);
        check("illegal_err", 32'(bus.err), 32'd1);
        check("illegal_we", 32'(bus.imem_we), 32'd0);
        check("illegal_ready", 32'(bus.in_ready), 32'd1);
        check("illegal_count", 32'(bus.words_written), 32'(exp_count));
        @(posedge clk); #1;
        check("illegal_we_late", 32'(bus.imem_we), 32'd0);
        write_word(4'd1, 3'd7, 3'd7, 3'd7, 10'h000, 16'h0000, 21'h00FF81, 1);
        check("err_sticky", 32'(bus.err), 32'd1);

        // in_valid alongside load_start is not accepted.
        bus.mnem = 4'd0; bus.in_valid = 1'b1;
        bus.start_addr = 8'h20; bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.load_start = 1'b0;
        exp_addr = 8'h20; exp_count = '0;
        check("ls_valid_we", 32'(bus.imem_we), 32'd0);
        check("ls_valid_err", 32'(bus.err), 32'd0);
        check("ls_valid_addr", 32'(bus.imem_addr), 32'h20);
        @(posedge clk); #1;
        check("ls_valid_we_late", 32'(bus.imem_we), 32'd0);

        // Last address: fills, then ignores bundles until restarted.
        load(8'hFF);
        write_word(4'd5, 3'd2, 3'd3, 3'd0, 10'h155, 16'h0000, 21'h044D55, 0);
        bus.mnem = 4'd0; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("full_we", 32'(bus.imem_we), 32'd0);
            check("full_ready", 32'(bus.in_ready), 32'd0);
            check("full_count", 32'(bus.words_written), 32'd1);
        end
        bus.in_valid = 1'b0;
        load(8'h00);

        for (int i = 0; i < 5; i++)
            write_word(t_mn[i], t_rs[i], t_rt[i], t_rd[i], t_im[i], 16'h0000, t_ex[i], i % 2);

        // Restart while a write awaits ack: abandoned and uncounted.
        send(4'd0, 3'd1, 3'd2, 3'd3, 10'h000, 16'h0000);
        check("abort_we_pre", 32'(bus.imem_we), 32'd1);
        load(8'h40);
        bus.imem_ack = 1'b1;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        check("stray_ack_count", 32'(bus.words_written), 32'd0);
        check("stray_ack_addr", 32'(bus.imem_addr), 32'h40);
        check("stray_ack_we", 32'(bus.imem_we), 32'd0);

        // Asynchronous reset in the middle of a write.
        send(4'd3, 3'd1, 3'd1, 3'd0, 10'h0AA, 16'h0000);
        check("async_we_pre", 32'(bus.imem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk); #1;
        rst = 1'b0;

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
